// File: rtl/ifetch_requester.sv
// Instruction fetch requester: owns the PC, issues one instruction-bus read at a
// time, presents the fetched word to decode with valid/ready, applies redirects
// and drops read data that a redirect has made stale.
module ifetch_requester #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        ireq_valid,
  output logic [31:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_addr_inv,
  output logic        out_last_jmp,
  input  logic        out_is_jmp,
  input  logic        redir_valid,
  input  logic [31:0] redir_pc
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_OUT
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        pend_q, pend_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic        last_jmp_q, last_jmp_d;
  logic        pc_mis;

  assign pc_mis = (pc_q[1:0] != 2'b00);

  // State and datapath registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      pend_q     <= 1'b0;
      pend_pc_q  <= '0;
      last_jmp_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      pend_q     <= pend_d;
      pend_pc_q  <= pend_pc_d;
      last_jmp_q <= last_jmp_d;
    end
  end

  // Next-state logic: request, wait for data, present, redirect handling
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    pend_d     = pend_q;
    pend_pc_d  = pend_pc_q;
    last_jmp_d = last_jmp_q;
    unique case (state_q)
      S_REQ: begin
        if (pc_mis) begin
          // No bus request for a misaligned PC; a redirect here simply
          // replaces the PC since nothing is in flight to drop.
          if (redir_valid) begin
            pc_d = redir_pc;
          end else begin
            instr_d = '0;
            state_d = S_OUT;
          end
        end else begin
          // Request stays stable; remember the newest redirect target.
          if (redir_valid) begin
            pend_d    = 1'b1;
            pend_pc_d = redir_pc;
          end
          if (iresp_addr_ok) state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (iresp_data_ok) begin
          if (pend_q || redir_valid) begin
            pc_d    = redir_valid ? redir_pc : pend_pc_q;
            pend_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            instr_d = iresp_data;
            state_d = S_OUT;
          end
        end else if (redir_valid) begin
          pend_d    = 1'b1;
          pend_pc_d = redir_pc;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          last_jmp_d = out_is_jmp;
          pc_d       = redir_valid ? redir_pc : pc_q + 32'd4;
          state_d    = S_REQ;
        end else if (redir_valid) begin
          pc_d    = redir_pc;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // Outputs decoded from registered state; ireq_valid is also gated by resetn
  // so it reads 0 while reset is held yet rises in the first cycle after release.
  always_comb begin
    ireq_valid   = resetn && (state_q == S_REQ) && !pc_mis;
    ireq_addr    = pc_q;
    out_valid    = (state_q == S_OUT);
    out_pc       = out_valid ? pc_q : '0;
    out_instr    = out_valid ? instr_q : '0;
    out_addr_inv = out_valid && pc_mis;
    out_last_jmp = out_valid && last_jmp_q;
  end

endmodule

// File: tb/tb_ifetch_requester.sv
// Bench for ifetch_requester: directed scenarios then random bus/consumer/redirect
// traffic, all checked against a program-order reference model.
module tb_ifetch_requester;

  localparam logic [31:0] RPC = 32'hbfc0_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        iresp_addr_ok = 1'b0;
  logic        iresp_data_ok = 1'b0;
  logic [31:0] iresp_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_addr_inv;
  logic        out_last_jmp;
  logic        out_is_jmp = 1'b0;
  logic        redir_valid = 1'b0;
  logic [31:0] redir_pc = '0;

  always #5 clk = ~clk;

  ifetch_requester #(.RESET_PC(RPC)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ireq_valid   (ireq_valid),
    .ireq_addr    (ireq_addr),
    .iresp_addr_ok(iresp_addr_ok),
    .iresp_data_ok(iresp_data_ok),
    .iresp_data   (iresp_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_instr    (out_instr),
    .out_addr_inv (out_addr_inv),
    .out_last_jmp (out_last_jmp),
    .out_is_jmp   (out_is_jmp),
    .redir_valid  (redir_valid),
    .redir_pc     (redir_pc)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: architectural next PC, delay-slot flag, and bus bookkeeping
  logic [31:0] arch_pc = RPC;
  logic        exp_last = 1'b0;
  logic        outst = 1'b0;
  logic [31:0] outst_addr = '0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_addr = '0;
  logic        prev_out_hold = 1'b0;
  int          idle = 0;
  int          dly = 0;
  int          wait_a = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h9bc8_0001;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Called at a negedge with inputs already driven: check outputs, advance model, wait a cycle
  task automatic step();
    logic xfer;
    #1;
    if (!resetn) begin
      chk1("rst_ireq_valid", ireq_valid, 1'b0);
      chk ("rst_ireq_addr", ireq_addr, RPC);
      chk1("rst_out_valid", out_valid, 1'b0);
      chk ("rst_out_pc", out_pc, 32'h0);
      chk ("rst_out_instr", out_instr, 32'h0);
      chk1("rst_out_addr_inv", out_addr_inv, 1'b0);
      chk1("rst_out_last_jmp", out_last_jmp, 1'b0);
      arch_pc = RPC; exp_last = 1'b0; outst = 1'b0;
      prev_hold = 1'b0; prev_out_hold = 1'b0; idle = 0; wait_a = 0; dly = 0;
    end else begin
      if (prev_hold) begin
        chk1("ireq_hold_valid", ireq_valid, 1'b1);
        chk ("ireq_hold_addr", ireq_addr, prev_addr);
      end else if (ireq_valid) begin
        chk ("ireq_addr", ireq_addr, arch_pc);
        chk1("one_outstanding", outst, 1'b0);
      end
      if (prev_out_hold) chk1("out_hold", out_valid, 1'b1);
      if (out_valid) begin
        chk ("out_pc", out_pc, arch_pc);
        chk1("out_addr_inv", out_addr_inv, arch_pc[1:0] != 2'b00);
        chk ("out_instr", out_instr, (arch_pc[1:0] != 2'b00) ? 32'h0 : mem(arch_pc));
        chk1("out_last_jmp", out_last_jmp, exp_last);
        chk1("no_req_while_out", ireq_valid, 1'b0);
      end
      if (out_valid || redir_valid) idle = 0; else idle++;
      chk1("liveness", idle > 20, 1'b0);

      xfer = out_valid && out_ready;
      if (outst && iresp_data_ok) outst = 1'b0;
      if (ireq_valid && iresp_addr_ok) begin
        outst = 1'b1;
        outst_addr = ireq_addr;
        dly = $urandom_range(0, 2);
      end
      prev_hold = ireq_valid && !iresp_addr_ok;
      prev_addr = ireq_addr;
      prev_out_hold = out_valid && !out_ready && !redir_valid;
      if (xfer) begin
        exp_last = out_is_jmp;
        arch_pc  = redir_valid ? redir_pc : arch_pc + 32'd4;
      end else if (redir_valid) begin
        arch_pc = redir_pc;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_in(input logic aok, input logic dok, input logic rdy,
                        input logic jmp, input logic rv, input logic [31:0] rpc);
    iresp_addr_ok = aok;
    iresp_data_ok = dok;
    iresp_data    = dok ? mem(outst_addr) : 32'h0;
    out_ready     = rdy;
    out_is_jmp    = jmp;
    redir_valid   = rv;
    redir_pc      = rpc;
  endtask

  task automatic drive_random();
    logic [31:0] r;
    iresp_addr_ok = ireq_valid && (wait_a >= 3 || $urandom_range(0, 1) == 1);
    if (ireq_valid && !iresp_addr_ok) wait_a++; else wait_a = 0;
    iresp_data_ok = 1'b0;
    iresp_data    = $urandom;
    if (outst) begin
      if (dly == 0) begin
        iresp_data_ok = 1'b1;
        iresp_data    = mem(outst_addr);
      end else begin
        dly--;
      end
    end
    out_ready   = ($urandom_range(0, 9) < 6);
    out_is_jmp  = ($urandom_range(0, 1) == 1);
    redir_valid = ($urandom_range(0, 11) == 0);
    r = $urandom & 32'hffff_fffc;
    if ($urandom_range(0, 7) == 0) r[1] = 1'b1;
    if ($urandom_range(0, 15) == 0) r = 32'hffff_fffc;
    redir_pc = r;
  endtask

  initial begin
    @(negedge clk);
    set_in(0, 0, 0, 0, 0, 32'h0);
    step(); step(); step();

    // T1: first fetch after reset release
    resetn = 1'b1;
    set_in(1, 0, 0, 0, 0, 32'h0);
    #1;
    chk1("t1_ireq_valid", ireq_valid, 1'b1);
    chk ("t1_ireq_addr", ireq_addr, 32'hbfc0_0000);
    step();
    set_in(0, 1, 0, 0, 0, 32'h0);
    step();
    chk1("t1_out_valid", out_valid, 1'b1);
    chk ("t1_out_pc", out_pc, 32'hbfc0_0000);
    chk ("t1_out_instr", out_instr, 32'h2408_0001);
    set_in(0, 0, 1, 0, 0, 32'h0);
    step();
    chk1("t1_out_gone", out_valid, 1'b0);
    chk1("t1_next_req", ireq_valid, 1'b1);
    chk ("t1_next_addr", ireq_addr, 32'hbfc0_0004);

    // T2: consumer stalls for 5 cycles
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    for (int i = 0; i < 5; i++) begin
      set_in(0, 0, 0, 0, 0, 32'h0);
      step();
      chk1("t2_out_valid", out_valid, 1'b1);
      chk ("t2_out_pc", out_pc, 32'hbfc0_0004);
      chk ("t2_out_instr", out_instr, mem(32'hbfc0_0004));
      chk1("t2_no_req", ireq_valid, 1'b0);
    end

    // T5: delay-slot flag follows the previous transferred instruction
    set_in(0, 0, 1, 1, 0, 32'h0); step();
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    chk ("t5_pc", out_pc, 32'hbfc0_0008);
    chk1("t5_last_jmp_set", out_last_jmp, 1'b1);
    set_in(0, 0, 1, 0, 0, 32'h0); step();
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    chk1("t5_last_jmp_clr", out_last_jmp, 1'b0);
    set_in(0, 0, 1, 0, 0, 32'h0); step();

    // T3: redirect while waiting for data; stale data dropped
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 0, 0, 0, 1, 32'h8000_0100); step();
    set_in(0, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    chk1("t3_no_out", out_valid, 1'b0);
    chk1("t3_req", ireq_valid, 1'b1);
    chk ("t3_addr", ireq_addr, 32'h8000_0100);

    // T4: misaligned redirect target, arriving while the request is held
    set_in(0, 0, 0, 0, 1, 32'h8000_0102); step();
    chk1("t4_hold_valid", ireq_valid, 1'b1);
    chk ("t4_hold_addr", ireq_addr, 32'h8000_0100);
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    chk1("t4_no_req", ireq_valid, 1'b0);
    set_in(0, 0, 0, 0, 0, 32'h0); step();
    chk1("t4_out_valid", out_valid, 1'b1);
    chk1("t4_addr_inv", out_addr_inv, 1'b1);
    chk ("t4_instr", out_instr, 32'h0);
    chk ("t4_pc", out_pc, 32'h8000_0102);

    // T6: transfer and redirect together, then reset mid-wait
    set_in(0, 0, 1, 0, 1, 32'h9000_0000); step();
    chk1("t6_req", ireq_valid, 1'b1);
    chk ("t6_addr", ireq_addr, 32'h9000_0000);
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    resetn = 1'b0;
    set_in(0, 0, 0, 0, 0, 32'h0);
    step(); step();
    resetn = 1'b1;
    set_in(0, 1, 0, 0, 0, 32'h0);
    #1;
    chk1("t6_rel_req", ireq_valid, 1'b1);
    chk ("t6_rel_addr", ireq_addr, 32'hbfc0_0000);
    step();
    chk1("t6_stray_no_out", out_valid, 1'b0);
    chk1("t6_stray_hold", ireq_valid, 1'b1);

    // PC wrap: 0xffff_fffc + 4 -> 0
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    set_in(0, 0, 0, 0, 1, 32'hffff_fffc); step();
    set_in(1, 0, 0, 0, 0, 32'h0); step();
    set_in(0, 1, 0, 0, 0, 32'h0); step();
    chk ("wrap_pc", out_pc, 32'hffff_fffc);
    set_in(0, 0, 1, 0, 0, 32'h0); step();
    chk1("wrap_req", ireq_valid, 1'b1);
    chk ("wrap_addr", ireq_addr, 32'h0);

    // Random traffic with one reset in the middle
    for (int i = 0; i < 1500; i++) begin
      if (i == 800) begin
        resetn = 1'b0;
        set_in(0, 0, 0, 0, 0, 32'h0);
        step(); step();
        resetn = 1'b1;
      end
      drive_random();
      step();
    end

    set_in(0, 0, 0, 0, 0, 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
